// File: rtl/move_cmd_queue_pkg.sv
// ============================================================================
// Module : move_cmd_queue_pkg
// Brief  : Move codes and queue-controller state encoding shared with the board engine
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package move_cmd_queue_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OFFER     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/move_cmd_queue_fifo.sv
// ============================================================================
// Module : move_cmd_queue_fifo
// Brief  : Synchronous FIFO for move codes. Push and pop may both happen in
//          one cycle while the FIFO is full.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_cmd_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_FULL);
  assign w_do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/move_cmd_queue.sv
// ============================================================================
// Module : move_cmd_queue
// Brief  : Priority-encodes debounced button presses into move codes, queues
//          them, and hands them one at a time to the board engine.
//          Optional drop counter built when MOVE_QUEUE_STATS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_cmd_queue
  import move_cmd_queue_pkg::*;
#(
  parameter int DEPTH  = 4
`ifdef MOVE_QUEUE_STATS_EN
  ,
  parameter int DROP_W = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   press_up,
  input  logic                   press_down,
  input  logic                   press_left,
  input  logic                   press_right,
  output logic                   move_valid,
  output logic [1:0]             move_dir,
  input  logic                   move_ready,
  input  logic                   board_done,
  output logic [$clog2(DEPTH):0] queue_count
`ifdef MOVE_QUEUE_STATS_EN
  ,
  output logic [DROP_W-1:0]      drop_count
`endif
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_any;
  logic       w_multi;
  logic [1:0] w_dir;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [1:0] w_head;

  assign w_any   = press_up | press_down | press_left | press_right;
  assign w_multi = (press_up   & (press_down | press_left | press_right)) |
                   (press_down & (press_left | press_right)) |
                   (press_left & press_right);

  always_comb begin
    w_dir = DIR_RIGHT;
    if (press_up)        w_dir = DIR_UP;
    else if (press_down) w_dir = DIR_DOWN;
    else if (press_left) w_dir = DIR_LEFT;
  end

  move_cmd_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_any),
    .pop   (w_pop),
    .din   (w_dir),
    .head  (w_head),
    .count (queue_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE:      if (!w_empty) w_state_nxt = ST_OFFER;
      ST_OFFER: begin
        if (move_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: if (board_done) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  assign move_valid = (r_state == ST_OFFER);
  // Head is forced to zero outside OFFER so the bus never shows stale slots.
  assign move_dir   = move_valid ? w_head : DIR_UP;

`ifdef MOVE_QUEUE_STATS_EN
  logic              w_drop;
  logic [DROP_W-1:0] r_drop;

  assign w_drop     = w_multi | (w_any & w_full & ~w_pop);
  assign drop_count = r_drop;

  always_ff @(posedge clk) begin
    if (rst)                         r_drop <= '0;
    else if (w_drop && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
  end
`else
  logic w_unused;
  assign w_unused = w_multi;
`endif

endmodule

`default_nettype wire

// File: tb/tb_move_cmd_queue.sv
// ============================================================================
// Module : tb_move_cmd_queue
// Brief  : Directed scenarios plus randomized traffic against a queue model
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       press_up = 1'b0, press_down = 1'b0, press_left = 1'b0, press_right = 1'b0;
  logic       move_ready = 1'b0, board_done = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [2:0] queue_count;
`ifdef MOVE_QUEUE_STATS_EN
  logic [7:0] drop_count;
`endif

  move_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .press_up    (press_up),
    .press_down  (press_down),
    .press_left  (press_left),
    .press_right (press_right),
    .move_valid  (move_valid),
    .move_dir    (move_dir),
    .move_ready  (move_ready),
    .board_done  (board_done),
    .queue_count (queue_count)
`ifdef MOVE_QUEUE_STATS_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: queued moves plus the engine-facing phase (0 idle, 1 offering, 2 busy)
  int mq[$];
  int mphase = 0;
  int mdrop  = 0;
  int np, pdir;
  bit pop_now, full_now, acc;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mphase = 0;
      mdrop  = 0;
    end else begin
      np   = int'(press_up) + int'(press_down) + int'(press_left) + int'(press_right);
      pdir = press_up ? 0 : press_down ? 1 : press_left ? 2 : 3;
      pop_now  = (mphase == 1) && move_ready;
      full_now = (mq.size() == DEPTH);
      acc      = (np > 0) && (!full_now || pop_now);
      if ((np > 1 || (np > 0 && !acc)) && mdrop < 255) mdrop++;
      case (mphase)
        0: if (mq.size() != 0) mphase = 1;
        1: if (move_ready) mphase = 2;
        default: if (board_done) mphase = 0;
      endcase
      if (pop_now) void'(mq.pop_front());
      if (acc) mq.push_back(pdir);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int ev, ed;
    ev = (mphase == 1) ? 1 : 0;
    ed = (ev == 1) ? mq[0] : 0;
    chk("model_valid", int'(move_valid), ev);
    chk("model_dir",   int'(move_dir), ed);
    chk("model_count", int'(queue_count), mq.size());
`ifdef MOVE_QUEUE_STATS_EN
    chk("model_drop",  int'(drop_count), mdrop);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic set_press(input bit u, input bit d, input bit l, input bit r);
    press_up = u; press_down = d; press_left = l; press_right = r;
  endtask

  initial begin
    int exp_order[4];
    exp_order[0] = 1; exp_order[1] = 2; exp_order[2] = 3; exp_order[3] = 2;

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_count", int'(queue_count), 0);
    chk("reset_valid", int'(move_valid), 0);
    chk("reset_dir",   int'(move_dir), 0);

    // single press: count at N+1, offered at N+2, popped on ready
    set_press(0, 0, 1, 0); tick(); set_press(0, 0, 0, 0);
    chk("t1_count1", int'(queue_count), 1);
    chk("t1_valid_n1", int'(move_valid), 0);
    move_ready = 1'b1; tick();
    chk("t1_valid_n2", int'(move_valid), 1);
    chk("t1_dir", int'(move_dir), 2);
    tick(); move_ready = 1'b0;
    chk("t1_wait_valid", int'(move_valid), 0);
    chk("t1_wait_count", int'(queue_count), 0);
    board_done = 1'b1; tick(); board_done = 1'b0;
    tick();
    chk("t1_idle_valid", int'(move_valid), 0);

    // simultaneous up+right keeps only up
    set_press(1, 0, 0, 1); tick(); set_press(0, 0, 0, 0);
    chk("t2_count", int'(queue_count), 1);
`ifdef MOVE_QUEUE_STATS_EN
    chk("t2_drop", int'(drop_count), 1);
`endif
    tick();
    chk("t2_valid", int'(move_valid), 1);
    chk("t2_dir", int'(move_dir), 0);

    // fill while engine stalls; fifth press is dropped
    set_press(0, 1, 0, 0); tick();
    set_press(0, 0, 1, 0); tick();
    set_press(0, 0, 0, 1); tick();
    chk("t3_full", int'(queue_count), 4);
    set_press(1, 0, 0, 0); tick(); set_press(0, 0, 0, 0);
    chk("t3_drop_full", int'(queue_count), 4);
`ifdef MOVE_QUEUE_STATS_EN
    chk("t3_drop_cnt", int'(drop_count), 2);
`endif

    // push and pop together while full
    move_ready = 1'b1; set_press(0, 0, 1, 0); tick();
    move_ready = 1'b0; set_press(0, 0, 0, 0);
    chk("t4_count", int'(queue_count), 4);
    chk("t4_valid", int'(move_valid), 0);

    // done in WAIT_DONE returns to IDLE, then OFFER; done in OFFER ignored
    board_done = 1'b1; tick(); board_done = 1'b0;
    chk("t5_idle", int'(move_valid), 0);
    tick();
    chk("t5_offer", int'(move_valid), 1);
    board_done = 1'b1; tick(); board_done = 1'b0;
    chk("t5_done_ignored", int'(move_valid), 1);

    for (int i = 0; i < 4; i++) begin
      chk("order_valid", int'(move_valid), 1);
      chk("order_dir", int'(move_dir), exp_order[i]);
      move_ready = 1'b1; tick(); move_ready = 1'b0;
      chk("order_count", int'(queue_count), 3 - i);
      board_done = 1'b1; tick(); board_done = 1'b0;
      tick();
    end
    chk("drained_valid", int'(move_valid), 0);

    // reset in WAIT_DONE with three entries flushes everything
    set_press(1, 0, 0, 0); tick();
    set_press(0, 1, 0, 0); tick();
    set_press(0, 0, 1, 0); tick();
    set_press(0, 0, 0, 0);
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    set_press(0, 0, 0, 1); tick(); set_press(0, 0, 0, 0);
    chk("t6_pre_count", int'(queue_count), 3);
    chk("t6_pre_valid", int'(move_valid), 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_count", int'(queue_count), 0);
    chk("t6_valid", int'(move_valid), 0);
    chk("t6_dir", int'(move_dir), 0);
`ifdef MOVE_QUEUE_STATS_EN
    chk("t6_drop", int'(drop_count), 0);
`endif
    tick();
    chk("t6_stays_idle", int'(move_valid), 0);

    // randomized traffic with alternating stall-heavy and fast-engine phases
    for (int c = 0; c < 3000; c++) begin
      int ready_pct;
      ready_pct = ((c / 150) % 2 == 0) ? 15 : 70;
      rst         = ($urandom_range(0, 299) == 0);
      press_up    = ($urandom_range(0, 99) < 12);
      press_down  = ($urandom_range(0, 99) < 12);
      press_left  = ($urandom_range(0, 99) < 12);
      press_right = ($urandom_range(0, 99) < 12);
      move_ready  = ($urandom_range(0, 99) < ready_pct);
      board_done  = ($urandom_range(0, 99) < 35);
      tick();
    end
    rst = 1'b0;
    set_press(0, 0, 0, 0);
    move_ready = 1'b0;
    board_done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
